// File: rtl/maxpool_relu_stage_if.sv
// BRAM-side bus of the max-pool stage: conv-map read port and pooled-map write port.
// Read data is expected one cycle after rd_en; neither port applies backpressure.
interface maxpool_relu_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maxpool_relu_stage.sv
// 2x2 stride-2 max-pool with optional ReLU, reading a conv map from BRAM and writing the pooled map.
// 6 cycles per window, done 6*OUT_DIM^2 cycles after the first read; no backpressure, BRAMs always ready.
module maxpool_relu_stage #(
    parameter int IN_DIM  = 56,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter bit RELU_EN = 1'b1
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic start,
    output logic busy,
    output logic done,
    maxpool_relu_stage_if.master bram
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam logic [ADDR_W-1:0] ROW_OFS  = ADDR_W'(IN_DIM);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(2);
    // From the last window of a row to the first of the next, skipping any odd trailing column.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IN_DIM - 2 * (OUT_DIM - 1));
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_DIM - 1);
    localparam logic [ADDR_W-1:0] LAST_WIN = ADDR_W'(OUT_DIM * OUT_DIM - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               tap_q, tap_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        col_q, col_d;
    logic [ADDR_W-1:0]        win_q, win_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic signed [DATA_W-1:0] rd_sdata;

    assign rd_sdata = bram.rd_data;

    function automatic logic [ADDR_W-1:0] tap_ofs(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return ADDR_W'(1);
            2'd2:    return ROW_OFS;
            default: return ROW_OFS + ADDR_W'(1);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        base_d    = base_q;
        col_d     = col_q;
        win_d     = win_q;
        max_d     = max_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    tap_d     = 2'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q;
                end
            end
            S_READ: begin
                // rd_data here belongs to the tap issued one cycle earlier (tap_q - 1).
                if (tap_q == 2'd1) begin
                    max_d = rd_sdata;
                end else if (tap_q != 2'd0 && rd_sdata > max_q) begin
                    max_d = rd_sdata;
                end
                if (tap_q == 2'd3) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d     = tap_q + 2'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + tap_ofs(tap_q + 2'd1);
                end
            end
            S_DRAIN: begin
                if (rd_sdata > max_q) begin
                    max_d = rd_sdata;
                end
                state_d   = S_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = win_q;
                wr_data_d = (RELU_EN && max_d[DATA_W-1]) ? '0 : max_d;
            end
            S_WRITE: begin
                tap_d = 2'd0;
                if (win_q == LAST_WIN) begin
                    state_d = S_DONE;
                    base_d  = '0;
                    col_d   = '0;
                    win_d   = '0;
                end else begin
                    state_d = S_READ;
                    rd_en_d = 1'b1;
                    win_d   = win_q + ADDR_W'(1);
                    if (col_q == LAST_COL) begin
                        col_d  = '0;
                        base_d = base_q + ROW_STEP;
                    end else begin
                        col_d  = col_q + ADDR_W'(1);
                        base_d = base_q + COL_STEP;
                    end
                    rd_addr_d = base_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            base_q    <= '0;
            col_q     <= '0;
            win_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            base_q    <= base_d;
            col_q     <= col_d;
            win_q     <= win_d;
            max_q     <= max_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bram.rd_en   = rd_en_q;
    assign bram.rd_addr = rd_addr_q;
    assign bram.wr_en   = wr_en_q;
    assign bram.wr_addr = wr_addr_q;
    assign bram.wr_data = wr_data_q;
endmodule

// File: tb/tb_maxpool_relu_stage.sv
// Bench for maxpool_relu_stage: a 4x4 ReLU instance and a 56x56 pass-through instance,
// each with a BRAM model, a pooling reference model and a write-port scoreboard.
module tb_maxpool_relu_stage;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NA = 4;
    localparam int NB = 56;
    localparam int WA = (NA / 2) * (NA / 2);
    localparam int WB = (NB / 2) * (NB / 2);

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    logic ACLK = 1'b0;
    logic rst_a_n, rst_b_n, start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];
    exp_t exp_q_a[$];
    exp_t exp_q_b[$];
    exp_t e_a, e_b;

    maxpool_relu_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    maxpool_relu_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    maxpool_relu_stage #(.IN_DIM(NA), .DATA_W(DW), .ADDR_W(AW), .RELU_EN(1'b1)) dut_a (
        .ACLK(ACLK), .ARESETn(rst_a_n), .start(start_a), .busy(busy_a), .done(done_a), .bram(bus_a)
    );
    maxpool_relu_stage #(.IN_DIM(NB), .DATA_W(DW), .ADDR_W(AW), .RELU_EN(1'b0)) dut_b (
        .ACLK(ACLK), .ARESETn(rst_b_n), .start(start_b), .busy(busy_b), .done(done_b), .bram(bus_b)
    );

    always #5 ACLK = ~ACLK;

    // Synchronous-read BRAMs: data one cycle after rd_en.
    always @(posedge ACLK) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
    always @(posedge ACLK) if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge ACLK) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (bus_a.wr_en === 1'b1) begin
            wr_cnt_a++;
            if (exp_q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_wr: addr=%0d data=0x%0h, no write required", bus_a.wr_addr, bus_a.wr_data);
            end else begin
                e_a = exp_q_a.pop_front();
                chk("a_wr_addr", 64'(bus_a.wr_addr), 64'(e_a.addr));
                chk("a_wr_data", 64'(bus_a.wr_data), 64'(e_a.data));
            end
        end
    end

    always @(negedge ACLK) begin
        if (done_b === 1'b1) done_cnt_b++;
        if (bus_b.wr_en === 1'b1) begin
            wr_cnt_b++;
            if (exp_q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected_wr: addr=%0d data=0x%0h, no write required", bus_b.wr_addr, bus_b.wr_data);
            end else begin
                e_b = exp_q_b.pop_front();
                chk("b_wr_addr", 64'(bus_b.wr_addr), 64'(e_b.addr));
                chk("b_wr_data", 64'(bus_b.wr_data), 64'(e_b.data));
            end
        end
    end

    function automatic logic rd_en_of(input bit sel);
        return sel ? bus_b.rd_en : bus_a.rd_en;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Reference: signed max of each 2x2 block, row-major; dut_a clamps negatives, dut_b does not.
    task automatic expect_run(input bit sel);
        int n, od, base, m, v;
        int taps[4];
        exp_t e;
        n  = sel ? NB : NA;
        od = n / 2;
        for (int r = 0; r < od; r++) begin
            for (int c = 0; c < od; c++) begin
                base = 2 * r * n + 2 * c;
                taps = '{base, base + 1, base + n, base + n + 1};
                m = sel ? $signed(mem_b[taps[0]]) : $signed(mem_a[taps[0]]);
                for (int k = 1; k < 4; k++) begin
                    v = sel ? $signed(mem_b[taps[k]]) : $signed(mem_a[taps[k]]);
                    if (v > m) m = v;
                end
                if (!sel && m < 0) m = 0;
                e.addr = r * od + c;
                e.data = m;
                if (sel) exp_q_b.push_back(e);
                else     exp_q_a.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_0000;
            1:       return $urandom;
            default: return 32'($urandom_range(0, 200)) - 32'd100;
        endcase
    endfunction

    // Cycle 1 is the first rd_en cycle; done lands on cycle 6*windows+1 and busy covers cycles 1..done.
    task automatic run_dut(input bit sel, input int nwin, input bit poke);
        int n, busy_hi, w0, d0, qsz;
        string p;
        p  = sel ? "b" : "a";
        w0 = sel ? wr_cnt_b : wr_cnt_a;
        d0 = sel ? done_cnt_b : done_cnt_a;
        expect_run(sel);
        @(negedge ACLK); set_start(sel, 1'b1);
        @(negedge ACLK); set_start(sel, 1'b0);
        chk({p, "_first_rd_latency"}, 64'(rd_en_of(sel)), 64'd1);
        n       = 1;
        busy_hi = busy_of(sel) ? 1 : 0;
        while (done_of(sel) !== 1'b1 && n < 6 * nwin + 20) begin
            @(negedge ACLK);
            n++;
            if (busy_of(sel) === 1'b1) busy_hi++;
            if (poke) set_start(sel, (n % 3 == 0) && done_of(sel) !== 1'b1);
        end
        set_start(sel, 1'b0);
        chk({p, "_done_cycle"}, 64'(n), 64'(6 * nwin + 1));
        chk({p, "_busy_cycles"}, 64'(busy_hi), 64'(6 * nwin + 1));
        @(negedge ACLK);
        chk({p, "_done_one_cycle"}, 64'(done_of(sel)), 64'd0);
        chk({p, "_busy_after_done"}, 64'(busy_of(sel)), 64'd0);
        chk({p, "_write_count"}, 64'((sel ? wr_cnt_b : wr_cnt_a) - w0), 64'(nwin));
        chk({p, "_done_count"}, 64'((sel ? done_cnt_b : done_cnt_a) - d0), 64'd1);
        qsz = sel ? exp_q_b.size() : exp_q_a.size();
        chk({p, "_writes_outstanding"}, 64'(qsz), 64'd0);
    endtask

    task automatic fill_ramp_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, d0;
        int ofs[4];
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge ACLK);
        chk("a_reset_outputs", 64'({busy_a, done_a, bus_a.rd_en, bus_a.wr_en, bus_a.rd_addr, bus_a.wr_addr, bus_a.wr_data}), 64'd0);
        chk("b_reset_outputs", 64'({busy_b, done_b, bus_b.rd_en, bus_b.wr_en, bus_b.rd_addr, bus_b.wr_addr, bus_b.wr_data}), 64'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (2) @(negedge ACLK);

        // Ramp map: pooled values 5, 7, 13, 15.
        fill_ramp_a();
        run_dut(1'b0, WA, 1'b0);

        // Random maps; the second run keeps pulsing start while busy.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) mem_a[i] = rand_word();
            run_dut(1'b0, WA, t == 1);
        end

        // All-negative first window must clamp to zero.
        for (int i = 0; i < 16; i++) mem_a[i] = rand_word();
        mem_a[0] = -32'sd1;
        mem_a[1] = -32'sd2;
        mem_a[4] = -32'sd5;
        mem_a[5] = -32'sd6;
        run_dut(1'b0, WA, 1'b0);

        // start held through DONE: one idle cycle, then a second run.
        for (int i = 0; i < 16; i++) mem_a[i] = rand_word();
        w0 = wr_cnt_a;
        d0 = done_cnt_a;
        expect_run(1'b0);
        expect_run(1'b0);
        @(negedge ACLK); start_a = 1'b1;
        n = 0;
        while (done_a !== 1'b1 && n < 60) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        chk("a_hold_idle_gap", 64'({busy_a, bus_a.rd_en}), 64'd0);
        @(negedge ACLK);
        chk("a_hold_restart", 64'({busy_a, bus_a.rd_en}), 64'd3);
        start_a = 1'b0;
        n = 0;
        while (done_a !== 1'b1 && n < 60) begin
            @(negedge ACLK);
            n++;
        end
        repeat (2) @(negedge ACLK);
        chk("a_hold_write_count", 64'(wr_cnt_a - w0), 64'(2 * WA));
        chk("a_hold_done_count", 64'(done_cnt_a - d0), 64'd2);

        // Reset during the second window aborts the run.
        fill_ramp_a();
        w0 = wr_cnt_a;
        expect_run(1'b0);
        @(negedge ACLK); start_a = 1'b1;
        @(negedge ACLK); start_a = 1'b0;
        repeat (8) @(negedge ACLK);
        chk("a_writes_before_reset", 64'(wr_cnt_a - w0), 64'd1);
        rst_a_n = 1'b0;
        #1;
        chk("a_reset_midrun_outputs", 64'({busy_a, done_a, bus_a.rd_en, bus_a.wr_en, bus_a.rd_addr, bus_a.wr_addr, bus_a.wr_data}), 64'd0);
        exp_q_a.delete();
        repeat (3) @(negedge ACLK);
        chk("a_reset_held_outputs", 64'({busy_a, done_a, bus_a.rd_en, bus_a.wr_en, bus_a.rd_addr, bus_a.wr_addr, bus_a.wr_data}), 64'd0);
        rst_a_n = 1'b1;
        repeat (20) @(negedge ACLK);
        chk("a_no_wr_after_reset", 64'(wr_cnt_a - w0), 64'd1);
        chk("a_idle_after_reset", 64'(busy_a), 64'd0);
        run_dut(1'b0, WA, 1'b0);

        // 56x56 pass-through: value 100 at each tap position, an all-minimum window, a negative window.
        ofs = '{0, 1, NB, NB + 1};
        for (int i = 0; i < 4096; i++) mem_b[i] = 32'h8000_0000;
        for (int k = 0; k < 4; k++) mem_b[2 * k + ofs[k]] = 32'd100;
        mem_b[2 * NB]          = -32'sd1;
        mem_b[2 * NB + 1]      = -32'sd2;
        mem_b[3 * NB]          = -32'sd5;
        mem_b[3 * NB + 1]      = -32'sd6;
        for (int i = 4 * NB; i < NB * NB; i++) mem_b[i] = rand_word();
        run_dut(1'b1, WB, 1'b0);

        for (int i = 0; i < NB * NB; i++) mem_b[i] = rand_word();
        run_dut(1'b1, WB, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
